// File: rtl/fu_complete_arbiter_pkg.sv
// Shared completion-path types and default sizing for the FU -> CDB arbiter.
`ifndef NUM_FU
`define NUM_FU 5
`endif
`ifndef CDB_WIDTH
`define CDB_WIDTH 2
`endif

package fu_complete_arbiter_pkg;

  localparam int DEF_NUM_FU    = `NUM_FU;
  localparam int DEF_CDB_WIDTH = `CDB_WIDTH;
  localparam int TAG_W         = 6;
  localparam int DATA_W        = 32;

  // Result packet as produced by a functional unit and broadcast on the CDB.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } FU_COMPLETE_PACKET;

endpackage

// File: rtl/fu_complete_arbiter_rr_select_n.sv
// Combinational round-robin picker: scans req starting at ptr (wrapping at N-1),
// grants the first K requesters and reports per-slot one-hot selects.
module rr_select_n #(
  parameter int N = 5,
  parameter int K = 2
) (
  input  logic [N-1:0]                  i_req,
  input  logic [((N>1)?$clog2(N):1)-1:0] i_ptr,
  output logic [N-1:0]                  o_grant,
  output logic [N-1:0]                  o_sel [K],
  output logic [((N>1)?$clog2(N):1)-1:0] o_last,
  output logic                          o_any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 1;

  logic [SW-1:0] w_sum;
  logic [PW-1:0] w_rot;
  int            w_cnt;

  // Walk the requesters in rotated order; wrap compares against N, not 2**PW.
  always_comb begin
    o_grant = '0;
    for (int k = 0; k < K; k++) o_sel[k] = '0;
    o_last = '0;
    w_sum  = '0;
    w_rot  = '0;
    w_cnt  = 0;
    for (int j = 0; j < N; j++) begin
      w_sum = SW'(i_ptr) + SW'(j);
      if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
      w_rot = w_sum[PW-1:0];
      if (i_req[w_rot] && (w_cnt < K)) begin
        o_grant[w_rot] = 1'b1;
        for (int k = 0; k < K; k++) begin
          if (w_cnt == k) o_sel[k][w_rot] = 1'b1;
        end
        o_last = w_rot;
        w_cnt  = w_cnt + 1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fu_complete_arbiter.sv
// Completion arbiter: grants up to CDB_WIDTH FUs per cycle round-robin, stalls
// the losers one cycle later, and registers the winners' packets onto the CDB.
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU    = DEF_NUM_FU,
  parameter int CDB_WIDTH = DEF_CDB_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_squash,
  input  logic [NUM_FU-1:0] i_want_to_complete,
  input  FU_COMPLETE_PACKET i_fu_packet_in [NUM_FU],
  output logic [NUM_FU-1:0] o_complete_stall,
  output FU_COMPLETE_PACKET o_cdb_packet_out [CDB_WIDTH]
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_sel [CDB_WIDTH];
  logic [PW-1:0]     w_last;
  logic              w_any;
  logic [PW-1:0]     w_rr_next;

  logic [NUM_FU-1:0] r_grant_q;
  logic [NUM_FU-1:0] r_stall_q;
  logic [PW-1:0]     r_rr_ptr;
  logic [NUM_FU-1:0] r_slot_sel [CDB_WIDTH];
  FU_COMPLETE_PACKET r_cdb [CDB_WIDTH];
  FU_COMPLETE_PACKET w_slot_pkt [CDB_WIDTH];

  rr_select_n #(.N(NUM_FU), .K(CDB_WIDTH)) u_rr_select (
    .i_req   (i_want_to_complete),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_sel   (w_sel),
    .o_last  (w_last),
    .o_any   (w_any)
  );

  assign w_rr_next = (w_last == PW'(NUM_FU - 1)) ? '0 : w_last + 1'b1;

  // Register this cycle's grants; a squash drops whatever is being requested now.
  always_ff @(posedge clock) begin
    if (reset || i_squash) r_grant_q <= '0;
    else                   r_grant_q <= w_grant;
  end

  // Losers are told to hold next cycle, aligned with the FU result-hold timing.
  always_ff @(posedge clock) begin
    if (reset || i_squash) r_stall_q <= '0;
    else                   r_stall_q <= i_want_to_complete & ~w_grant;
  end

  // Pointer moves past the last winner; squash leaves it where it was.
  always_ff @(posedge clock) begin
    if (reset)                        r_rr_ptr <= '0;
    else if (!i_squash && w_any)      r_rr_ptr <= w_rr_next;
  end

  // Remember which FU feeds each CDB slot for the select cycle.
  always_ff @(posedge clock) begin
    if (reset || i_squash) begin
      for (int k = 0; k < CDB_WIDTH; k++) r_slot_sel[k] <= '0;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) r_slot_sel[k] <= w_sel[k];
    end
  end

  // Select the granted packets; an invalid packet from a winner leaves an empty slot.
  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      w_slot_pkt[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (r_slot_sel[k][i] && r_grant_q[i] && i_fu_packet_in[i].valid)
          w_slot_pkt[k] = i_fu_packet_in[i];
      end
    end
  end

  // CDB output register; each result is presented for exactly one cycle.
  always_ff @(posedge clock) begin
    if (reset || i_squash) begin
      for (int k = 0; k < CDB_WIDTH; k++) r_cdb[k] <= '0;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) r_cdb[k] <= w_slot_pkt[k];
    end
  end

  assign o_complete_stall = r_stall_q;
  assign o_cdb_packet_out = r_cdb;

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter (NUM_FU=5, CDB_WIDTH=2).
module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [4:0]        want;
  FU_COMPLETE_PACKET pkt [5];
  logic [4:0]        stall;
  FU_COMPLETE_PACKET cdb [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_stall [6] = '{5'b11100, 5'b10011, 5'b01110, 5'b11001, 5'b00111, 5'b11100};
  int         exp_s0    [6] = '{-1, 0, 2, 4, 1, 3};
  int         exp_s1    [6] = '{-1, 1, 3, 0, 2, 4};

  fu_complete_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .i_squash           (squash),
    .i_want_to_complete (want),
    .i_fu_packet_in     (pkt),
    .o_complete_stall   (stall),
    .o_cdb_packet_out   (cdb)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // fu < 0 means the slot must be completely empty.
  task automatic chk_slot(input string tag, input int k, input int fu);
    logic [63:0] e;
    e = (fu < 0) ? 64'd0 : 64'(pkt[fu]);
    chk(tag, 64'(cdb[k]), e);
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    want   = '0;
    for (int i = 0; i < 5; i++) begin
      pkt[i].valid = 1'b1;
      pkt[i].tag   = 6'(i + 1);
      pkt[i].value = 32'hC0DE_0000 + 32'(i);
    end
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_stall", 64'(stall), 64'd0);
      chk_slot("idle_s0", 0, -1);
      chk_slot("idle_s1", 1, -1);
      chk("idle_ptr", 64'(dut.r_rr_ptr), 64'd0);
    end

    // 2: want=00111 from ptr 0
    want = 5'b00111;
    tick();
    chk("t2_stall", 64'(stall), 64'b00100);
    want = 5'b00000;
    tick();
    chk_slot("t2_s0", 0, 0);
    chk_slot("t2_s1", 1, 1);
    chk("t2_ptr", 64'(dut.r_rr_ptr), 64'd2);
    chk("t2_stall_clr", 64'(stall), 64'd0);
    tick();
    chk_slot("t2_once_s0", 0, -1);
    chk_slot("t2_once_s1", 1, -1);

    // 3: all five requesting from ptr 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    want = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("t3_stall_%0d", c), 64'(stall), 64'(exp_stall[c]));
      chk_slot($sformatf("t3_s0_%0d", c), 0, exp_s0[c]);
      chk_slot($sformatf("t3_s1_%0d", c), 1, exp_s1[c]);
    end
    want = 5'b00000;
    tick();
    chk_slot("t3_tail_s0", 0, 0);
    chk_slot("t3_tail_s1", 1, 1);
    chk("t3_ptr", 64'(dut.r_rr_ptr), 64'd2);

    // 4: move ptr to 4, then want=10001 wraps
    want = 5'b01000;
    tick();
    chk("t4_ptr4", 64'(dut.r_rr_ptr), 64'd4);
    want = 5'b10001;
    tick();
    chk("t4_ptr1", 64'(dut.r_rr_ptr), 64'd1);
    chk("t4_stall", 64'(stall), 64'd0);
    chk_slot("t4_prev_s0", 0, 3);
    chk_slot("t4_prev_s1", 1, -1);
    want = 5'b00000;
    tick();
    chk_slot("t4_s0", 0, 4);
    chk_slot("t4_s1", 1, 0);

    // 5: granted FU2 presents an invalid packet
    want = 5'b00100;
    tick();
    chk("t5_stall", 64'(stall), 64'd0);
    chk("t5_ptr", 64'(dut.r_rr_ptr), 64'd3);
    pkt[2].valid = 1'b0;
    want = 5'b00000;
    tick();
    chk_slot("t5_s0", 0, -1);
    chk_slot("t5_s1", 1, -1);
    pkt[2].valid = 1'b1;

    // 6: squash right after a grant; requests during squash are dropped
    want = 5'b00011;
    tick();
    chk("t6_ptr_pre", 64'(dut.r_rr_ptr), 64'd2);
    squash = 1'b1;
    want = 5'b11100;
    tick();
    chk("t6_stall", 64'(stall), 64'd0);
    chk_slot("t6_s0", 0, -1);
    chk_slot("t6_s1", 1, -1);
    chk("t6_ptr_kept", 64'(dut.r_rr_ptr), 64'd2);
    squash = 1'b0;
    want = 5'b00000;
    tick();
    chk_slot("t6_drop_s0", 0, -1);
    chk_slot("t6_drop_s1", 1, -1);
    chk("t6_drop_stall", 64'(stall), 64'd0);

    // reset mid-stream
    want = 5'b11111;
    tick();
    chk("rst_pre_stall", 64'(stall), 64'b10011);
    reset = 1'b1;
    tick();
    chk("rst_stall", 64'(stall), 64'd0);
    chk_slot("rst_s0", 0, -1);
    chk_slot("rst_s1", 1, -1);
    chk("rst_ptr", 64'(dut.r_rr_ptr), 64'd0);
    reset = 1'b0;
    want = 5'b00000;
    tick();
    chk_slot("rst_post_s0", 0, -1);
    chk_slot("rst_post_s1", 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
